// File: rtl/edge_merge_pkg.sv
// Shared types and constants for the edge_merge block.
package edge_merge_pkg;
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    STREAM  = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  localparam logic [7:0] EDGE_PIX   = 8'hFF;
  localparam logic [7:0] NOEDGE_PIX = 8'h00;
  localparam int         MAX_PIXELS = 32768;
endpackage

// File: rtl/edge_merge_plane.sv
// One-bit-per-pixel frame store: one write port, one combinational read port, synchronous clear.
module edge_plane #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic          clr,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);
  logic [DEPTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      mem_d = '0;
    end else if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/edge_merge.sv
// Merges two directional edge planes and streams the OR'd map out in raster order.
module edge_merge
  import edge_merge_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              a_valid,
  input  logic [7:0]        a_edge,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_done,
  input  logic              b_valid,
  input  logic [7:0]        b_edge,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_done,
  output logic              pix_valid,
  output logic [7:0]        pix_out,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_last,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              err
);
  localparam int PIX = IMG_W * IMG_H;
  localparam int PAW = (PIX > 1) ? $clog2(PIX) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIX - 1);

  if (PIX > MAX_PIXELS) begin : g_size_check
    $error("edge_merge: IMG_W*IMG_H exceeds MAX_PIXELS");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d, last_q, last_d;
  logic [7:0]        out_q, out_d;
  logic              fdone_q, fdone_d, err_q, err_d;
  logic              a_seen_q, a_seen_d, b_seen_q, b_seen_d;

  logic              a_ok, b_ok, a_we, b_we, a_bad, b_bad, plane_clr;
  logic              a_rd, b_rd, a_bit, b_bit;
  logic [ADDR_W-1:0] rd_idx;

  assign a_ok  = 32'(a_addr) < 32'(PIX);
  assign b_ok  = 32'(b_addr) < 32'(PIX);
  assign a_we  = enb & a_valid & a_ok & (state_q == COLLECT);
  assign b_we  = enb & b_valid & b_ok & (state_q == COLLECT);
  assign a_bad = enb & a_valid & (~a_ok | (state_q != COLLECT));
  assign b_bad = enb & b_valid & (~b_ok | (state_q != COLLECT));
  assign plane_clr = enb & (state_q == FLUSH);

  // Pre-fetch the pixel that the output register loads next.
  assign rd_idx = (state_q != STREAM || idx_q == LAST) ? '0 : idx_q + ADDR_W'(1);

  edge_plane #(.DEPTH(PIX), .AW(PAW)) u_plane_a (
    .clk   (clk),
    .reset (reset),
    .we    (a_we),
    .waddr (a_addr[PAW-1:0]),
    .wdata (a_edge != 8'h00),
    .clr   (plane_clr),
    .raddr (rd_idx[PAW-1:0]),
    .rdata (a_rd)
  );

  edge_plane #(.DEPTH(PIX), .AW(PAW)) u_plane_b (
    .clk   (clk),
    .reset (reset),
    .we    (b_we),
    .waddr (b_addr[PAW-1:0]),
    .wdata (b_edge != 8'h00),
    .clr   (plane_clr),
    .raddr (rd_idx[PAW-1:0]),
    .rdata (b_rd)
  );

  // A write to pixel 0 in the cycle that completes COLLECT must reach the first output.
  assign a_bit = (a_we && a_addr == rd_idx) ? (a_edge != 8'h00) : a_rd;
  assign b_bit = (b_we && b_addr == rd_idx) ? (b_edge != 8'h00) : b_rd;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    last_d   = last_q;
    out_d    = out_q;
    fdone_d  = fdone_q;
    err_d    = err_q;
    a_seen_d = a_seen_q;
    b_seen_d = b_seen_q;
    if (enb) begin
      fdone_d = 1'b0;
      err_d   = err_q | a_bad | b_bad;
      case (state_q)
        COLLECT: begin
          a_seen_d = a_seen_q | a_done;
          b_seen_d = b_seen_q | b_done;
          if (a_seen_d && b_seen_d) begin
            state_d = STREAM;
            idx_d   = '0;
            valid_d = 1'b1;
            out_d   = (a_bit | b_bit) ? EDGE_PIX : NOEDGE_PIX;
            last_d  = (LAST == '0);
          end
        end
        STREAM: begin
          if (valid_q && pix_ready) begin
            if (last_q) begin
              state_d = FLUSH;
              valid_d = 1'b0;
              last_d  = 1'b0;
              fdone_d = 1'b1;
            end else begin
              idx_d  = rd_idx;
              out_d  = (a_bit | b_bit) ? EDGE_PIX : NOEDGE_PIX;
              last_d = (rd_idx == LAST);
            end
          end
        end
        FLUSH: begin
          a_seen_d = 1'b0;
          b_seen_d = 1'b0;
          state_d  = COLLECT;
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= COLLECT;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      out_q    <= NOEDGE_PIX;
      fdone_q  <= 1'b0;
      err_q    <= 1'b0;
      a_seen_q <= 1'b0;
      b_seen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      out_q    <= out_d;
      fdone_q  <= fdone_d;
      err_q    <= err_d;
      a_seen_q <= a_seen_d;
      b_seen_q <= b_seen_d;
    end
  end

  assign pix_valid  = valid_q;
  assign pix_out    = out_q;
  assign pix_addr   = idx_q;
  assign pix_last   = last_q;
  assign frame_done = fdone_q;
  assign err        = err_q;
endmodule

// File: tb/tb_edge_merge.sv
// Scoreboard bench for edge_merge on a 4x4 image: directed scenarios plus randomized frames.
module tb_edge_merge;
  localparam int W = 4, H = 4, N = W * H, AW = 15;

  logic clk = 1'b0;
  logic reset, enb, pix_ready;
  logic a_valid, a_done, b_valid, b_done;
  logic [7:0] a_edge, b_edge;
  logic [AW-1:0] a_addr, b_addr;
  logic pix_valid, pix_last, frame_done, err;
  logic [7:0] pix_out;
  logic [AW-1:0] pix_addr;

  edge_merge #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .enb(enb),
    .a_valid(a_valid), .a_edge(a_edge), .a_addr(a_addr), .a_done(a_done),
    .b_valid(b_valid), .b_edge(b_edge), .b_addr(b_addr), .b_done(b_done),
    .pix_valid(pix_valid), .pix_out(pix_out), .pix_addr(pix_addr), .pix_last(pix_last),
    .pix_ready(pix_ready), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [7:0] data; bit last; } pix_t;
  pix_t sbq[$];
  pix_t mon_e;

  int checks = 0, failures = 0;
  bit ma[N], mb[N];
  bit sa = 0, sb = 0, collecting = 1, err_exp = 0;
  bit fd_exp = 0, fd_nxt, stalled = 0;
  logic [7:0] prev_out;
  logic [AW-1:0] prev_addr;
  logic prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: OR of the two model planes, emitted in raster order.
  task automatic push_frame();
    for (int i = 0; i < N; i++) begin
      sbq.push_back('{i, (ma[i] | mb[i]) ? 8'hFF : 8'h00, i == N - 1});
      ma[i] = 0;
      mb[i] = 0;
    end
    sa = 0;
    sb = 0;
  endtask

  task automatic wr(input bit va, input bit vb, input int aa, input int ab,
                    input bit ea, input bit eb, input bit da, input bit db);
    bit e, completes;
    a_valid = va; a_addr = AW'(aa); a_edge = ea ? 8'($urandom_range(1, 255)) : 8'h00; a_done = da;
    b_valid = vb; b_addr = AW'(ab); b_edge = eb ? 8'($urandom_range(1, 255)) : 8'h00; b_done = db;
    e = enb;
    completes = collecting && e && (sa || da) && (sb || db);
    if (completes) chk("valid_before_done", pix_valid, 0);
    @(posedge clk); #1;
    if (e) begin
      if (collecting) begin
        if (va) begin if (aa < N) ma[aa] = ea; else err_exp = 1; end
        if (vb) begin if (ab < N) mb[ab] = eb; else err_exp = 1; end
        sa = sa | da;
        sb = sb | db;
        if (sa && sb) begin
          push_frame();
          collecting = 0;
          chk("latency_valid", pix_valid, 1);
          chk("latency_addr", pix_addr, 0);
        end
      end else if (va || vb) begin
        err_exp = 1;
      end
    end
    a_valid = 0; b_valid = 0; a_done = 0; b_done = 0;
  endtask

  // mode 0: ready high, 1: alternating with a 3-cycle enb gap, 2: random ready
  task automatic run_stream(input int mode, input bit enb_rand, input bit wr_rand, output int cyc);
    bit e, wv;
    cyc = 0;
    while (sbq.size() != 0 || frame_done) begin
      if (cyc >= 400) begin
        checks++; failures++;
        $display("FAIL stream_timeout: %0d pixels pending, required 0", sbq.size());
        sbq.delete();
        break;
      end
      case (mode)
        0: pix_ready = 1;
        1: pix_ready = (cyc % 2 == 0);
        default: pix_ready = $urandom_range(0, 1);
      endcase
      if (mode == 1) enb = !(cyc >= 6 && cyc < 9);
      else enb = enb_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
      wv = wr_rand && (cyc == 2 || $urandom_range(0, 5) == 0);
      a_valid = wv; a_addr = AW'($urandom_range(0, N - 1)); a_edge = 8'hA5;
      b_valid = wr_rand && ($urandom_range(0, 7) == 0);
      b_addr = AW'($urandom_range(0, N - 1)); b_edge = 8'h3C;
      e = enb;
      @(posedge clk); #1;
      if (e && (a_valid || b_valid)) err_exp = 1;
      a_valid = 0; b_valid = 0;
      cyc++;
    end
    enb = 1;
    collecting = 1;
  endtask

  task automatic rand_collect();
    int n;
    n = $urandom_range(5, 25);
    for (int k = 0; k < n; k++) begin
      enb = ($urandom_range(0, 4) != 0);
      wr($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, N + 3), $urandom_range(0, N + 3),
         $urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
    end
    enb = 1;
    if ($urandom_range(0, 1) == 1) begin
      wr(0, 1, 0, $urandom_range(0, N - 1), 0, 1, 0, 1);
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) wr(0, 0, 0, 0, 0, 0, 0, 0);
      wr(1, 0, $urandom_range(0, N - 1), 0, 1, 0, 1, 0);
    end else begin
      wr(1, 1, 0, $urandom_range(0, N - 1), 1, 1, 1, 1);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      stalled = 0;
      fd_exp = 0;
    end else begin
      chk("frame_done", frame_done, fd_exp);
      chk("err", err, err_exp);
      if (stalled) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_out", pix_out, prev_out);
        chk("stall_addr", pix_addr, prev_addr);
        chk("stall_last", pix_last, prev_last);
      end
      fd_nxt = fd_exp && !enb;
      if (pix_valid && pix_ready && enb) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_pixel: addr %0d data %0h, required none", pix_addr, pix_out);
        end else begin
          mon_e = sbq.pop_front();
          chk("pix_addr", pix_addr, mon_e.addr);
          chk("pix_out", pix_out, mon_e.data);
          chk("pix_last", pix_last, mon_e.last);
          if (mon_e.last) fd_nxt = 1;
        end
        stalled = 0;
      end else begin
        stalled = pix_valid;
        prev_out = pix_out;
        prev_addr = pix_addr;
        prev_last = pix_last;
      end
      fd_exp = fd_nxt;
    end
  end

  initial begin
    int cyc;
    bit found;
    reset = 1; enb = 1; pix_ready = 0;
    a_valid = 0; a_edge = 0; a_addr = 0; a_done = 0;
    b_valid = 0; b_edge = 0; b_addr = 0; b_done = 0;
    #3;
    chk("rst_valid", pix_valid, 0); chk("rst_out", pix_out, 0); chk("rst_addr", pix_addr, 0);
    chk("rst_last", pix_last, 0); chk("rst_fdone", frame_done, 0); chk("rst_err", err, 0);
    @(negedge clk); @(negedge clk); #1 reset = 0;
    @(posedge clk); #1;

    // basic merge
    wr(1, 0, 0, 0, 1, 0, 0, 0);
    wr(1, 1, 5, 5, 1, 1, 0, 0);
    wr(0, 1, 0, 15, 0, 1, 0, 0);
    pix_ready = 1;
    wr(0, 0, 0, 0, 0, 0, 1, 1);
    run_stream(0, 0, 0, cyc);
    chk("frame_cycles", cyc, N + 1);

    // done ordering, valid sample in the done cycle
    wr(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 9; k++) wr(0, 0, 0, 0, 0, 0, 0, 0);
    wr(1, 0, 3, 0, 1, 0, 1, 0);
    run_stream(0, 0, 0, cyc);

    // backpressure with enb gap
    wr(1, 1, 2, 9, 1, 1, 0, 0);
    wr(1, 0, 14, 0, 1, 0, 1, 1);
    run_stream(1, 0, 0, cyc);

    // errors: out-of-range writes and writes during STREAM/FLUSH
    wr(1, 1, 16, 16, 1, 1, 0, 0);
    wr(1, 1, 0, 5, 1, 1, 0, 0);
    wr(0, 1, 0, 15, 0, 1, 1, 1);
    run_stream(2, 0, 1, cyc);
    chk("err_sticky", err, 1);

    // reset mid-stream at index 7
    wr(1, 0, 3, 0, 1, 0, 0, 0);
    wr(0, 1, 0, 10, 0, 1, 0, 0);
    pix_ready = 1;
    wr(0, 0, 0, 0, 0, 0, 1, 1);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (pix_valid && pix_addr == 7) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("reached_idx7", found, 1);
    #1 reset = 1;
    #1;
    chk("mrst_valid", pix_valid, 0); chk("mrst_out", pix_out, 0); chk("mrst_addr", pix_addr, 0);
    chk("mrst_last", pix_last, 0); chk("mrst_fdone", frame_done, 0); chk("mrst_err", err, 0);
    sbq.delete();
    err_exp = 0; collecting = 1; sa = 0; sb = 0;
    for (int i = 0; i < N; i++) begin ma[i] = 0; mb[i] = 0; end
    @(negedge clk); #1 reset = 0;
    @(posedge clk); #1;
    wr(0, 0, 0, 0, 0, 0, 1, 1);
    run_stream(0, 0, 0, cyc);

    // back-to-back frames
    wr(1, 1, 1, 12, 1, 1, 0, 0);
    wr(1, 0, 9, 0, 1, 0, 1, 1);
    run_stream(0, 0, 0, cyc);
    wr(1, 0, 2, 0, 1, 0, 1, 1);
    run_stream(0, 0, 0, cyc);

    for (int f = 0; f < 8; f++) begin
      rand_collect();
      run_stream(2, 1, 1, cyc);
    end

    repeat (3) @(posedge clk);
    #1 chk("queue_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/edge_merge.md
# edge_merge

Merges the binary edge streams of two directional edge-detection units (e.g. across and down) into one edge map, then streams the merged map out in raster order for the image writer. It sits directly downstream of the edge-detection stage: it consumes each unit's per-pixel edge bit, pixel index and completion flag. It holds a full frame in two 1-bit planes, waits until both directions are complete, and emits `0xFF`/`0x00` pixels under a valid/ready handshake.

## Interface
- `IMG_W`, 64: image width in pixels.
- `IMG_H`, 64: image height in pixels. `IMG_W*IMG_H` must not exceed 32768.
- `ADDR_W`, 15: pixel index width. This matches the 15-bit counter of the edge-detection stage.

- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `enb` in 1: global enable. When low, all state, counters and outputs hold.
- `a_valid` in 1: stream A edge sample is present.
- `a_edge` in 8: stream A edge value. Any nonzero value is an edge.
- `a_addr` in ADDR_W: raster pixel index of the A sample.
- `a_done` in 1: stream A frame complete (level or pulse).
- `b_valid`, `b_edge`, `b_addr`, `b_done`: same as A, for stream B.
- `pix_valid` out 1: merged pixel is present.
- `pix_out` out 8: `0xFF` if edge, `0x00` if not.
- `pix_addr` out ADDR_W: raster index of `pix_out`.
- `pix_last` out 1: asserted with the final pixel (index `IMG_W*IMG_H-1`).
- `pix_ready` in 1: downstream accepts the pixel.
- `frame_done` out 1: one-cycle pulse after the last pixel transfers.
- `err` out 1: sticky error. Set by an out-of-range address or by a write arriving during STREAM. Cleared only by reset.

## Operation
- FSM states: COLLECT, STREAM, FLUSH. Reset state is COLLECT.
- **COLLECT**
  - `a_valid` writes `plane_a[a_addr] <= (a_edge != 0)`. `b_valid` writes `plane_b` the same way.
  - A and B writes are independent and may occur in the same cycle, including to the same index.
  - Sticky flags `a_seen` and `b_seen` are set by `a_done` and `b_done`.
  - A sample with `valid` high in the same cycle as its `done` is still written.
  - When both flags are set (counting the current cycle), the next state is STREAM and the read index is set to 0.
- **STREAM**
  - `pix_out = (plane_a[idx] | plane_b[idx]) ? 0xFF : 0x00` and `pix_addr = idx`.
  - On `pix_valid & pix_ready`, `idx` increments.
  - A transfer with `pix_last` high moves the FSM to FLUSH.
  - A/B writes arriving in this state are dropped and set `err`.
- **FLUSH** (one cycle)
  - Both planes are cleared, `a_seen`/`b_seen` are cleared, `frame_done` pulses, and the FSM returns to COLLECT.
  - A/B writes in this cycle are dropped and set `err`.
- Address rule: a write with `addr >= IMG_W*IMG_H` is ignored and sets `err`.
- Reset mid-operation clears both planes, both flags, `idx` and `err`, and aborts any stream.
- Reset value of every output: `pix_valid=0`, `pix_out=0x00`, `pix_addr=0`, `pix_last=0`, `frame_done=0`, `err=0`.

## Timing
- All outputs are registered.
- A write is visible to a read one cycle later.
- Latency: `pix_valid` rises 1 cycle after the cycle in which the second `done` is sampled.
- Throughput: 1 pixel/cycle while `pix_ready` is high.
- Full frame with `pix_ready` held high: `IMG_W*IMG_H` STREAM cycles plus 1 FLUSH cycle.
- Handshake: while `pix_valid & !pix_ready`, `pix_out`, `pix_addr` and `pix_last` are stable.
  - `pix_valid` does not drop until the transfer occurs.
  - `pix_ready` may toggle freely; it has no combinational path to any output.
- `enb` low freezes the FSM, `idx` and the output registers, including during backpressure.
  - A/B inputs are not sampled while `enb` is low.
  - `frame_done` extends if `enb` drops in the FLUSH cycle.
- `frame_done` rises the cycle after the `pix_last` transfer.
- The first COLLECT write of the next frame is accepted the cycle after that.

## Structure
- Shared package `edge_merge_pkg` holds:
  - the state enum (COLLECT/STREAM/FLUSH);
  - `EDGE_PIX = 8'hFF`, `NOEDGE_PIX = 8'h00`;
  - `MAX_PIXELS = 32768`, used for the parameter-range check.
- Sub-module `edge_plane`, instantiated twice (A and B):
  - `IMG_W*IMG_H`-bit storage;
  - 1 write port and 1 read port;
  - single-cycle synchronous clear;
  - asynchronous reset to all-zero.
- The FSM, `idx` counter, sticky flags and output register live in `edge_merge`.

## Test plan
- **Basic merge** (4×4 image): A writes edges at 0 and 5; B writes at 5 and 15; both dones; `pix_ready=1`.
  - Expect 16 pixels, `0xFF` at indices 0, 5 and 15, `0x00` elsewhere.
  - Expect `pix_last` at index 15 and `frame_done` one cycle later.
- **Done ordering**: `b_done` 10 cycles before `a_done`; `a_valid` with index 3 in the same cycle as `a_done`.
  - Expect index 3 = `0xFF`.
  - Expect `pix_valid` exactly 1 cycle after `a_done`.
- **Backpressure**: `pix_ready` alternating 1/0 with `enb` low for 3 cycles mid-stream.
  - Expect outputs held stable while stalled.
  - Expect no pixel skipped or duplicated and all 16 indices delivered in order.
- **Errors**: write to index 16 (4×4 image) and a write during STREAM.
  - Expect `err=1`, both writes dropped and output identical to the error-free frame.
- **Reset mid-stream**: assert `reset` at index 7.
  - Expect all outputs 0 immediately.
  - A new frame with no edges then streams all `0x00` (planes cleared).
- **Back-to-back frames**: frame 2 has edges only at index 2.
  - Expect frame-1 edges absent from frame 2.
